// File: rtl/wiz_bus_cycle.sv
// rtl/wiz_bus_cycle.sv - 68008 to W5300 bus cycle sequencer with parameterised setup/strobe/hold/recovery timing
module wiz_bus_cycle #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned RECOV_CYC  = 2
) (
  input  logic clk,
  input  logic rstl,
  input  logic wizsel,
  input  logic dsl,
  input  logic rdwl,
  output logic wizcsl,
  output logic wizrdl,
  output logic wizwrl,
  output logic dbenl,
  output logic dbdir,
  output logic dtackl,
  output logic busy
);

  // Terminal count of a phase; a zero length is stretched to one cycle.
  function automatic logic [3:0] last_cnt(input int unsigned n);
    if (n == 0)     return 4'd0;
    else if (n > 15) return 4'd14;
    else            return 4'(n - 1);
  endfunction

  localparam logic [3:0] SETUP_LAST  = last_cnt(SETUP_CYC);
  localparam logic [3:0] STROBE_LAST = last_cnt(STROBE_CYC);
  localparam logic [3:0] HOLD_LAST   = last_cnt(HOLD_CYC);
  localparam logic [3:0] RECOV_LAST  = last_cnt(RECOV_CYC);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK, RECOV} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        abort_q, abort_d;
  logic        armed_q, armed_d;
  logic        sel_s1_q, sel_s2_q, ds_s1_q, ds_s2_q;
  logic [1:0]  vld_q;
  logic        lost;
  logic        cs_q, rd_q, wr_q, ben_q, dbdir_q, dtack_q, busy_q;
  logic        cs_d, rd_d, wr_d, ben_d, dbdir_d, dtack_d, busy_d;

  // armed marks a genuine high level of synchronised dsl since the last start,
  // so a strobe still held low from a previous cycle cannot retrigger.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    dir_d   = dir_q;
    abort_d = abort_q;
    armed_d = armed_q | (vld_q[1] & ds_s2_q);
    lost    = ~sel_s2_q | ds_s2_q;
    case (state_q)
      IDLE: begin
        cnt_d   = 4'd0;
        abort_d = 1'b0;
        if (armed_q && sel_s2_q && !ds_s2_q) begin
          state_d = SETUP;
          dir_d   = rdwl;
          armed_d = 1'b0;
        end
      end
      SETUP: begin
        if (lost) begin
          state_d = RECOV;
          cnt_d   = 4'd0;
        end else if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = 4'd0;
        end
      end
      STROBE: begin
        abort_d = abort_q | lost;
        if (cnt_q == STROBE_LAST) begin
          state_d = HOLD;
          cnt_d   = 4'd0;
        end
      end
      HOLD: begin
        abort_d = abort_q | lost;
        if (cnt_q == HOLD_LAST) begin
          state_d = (abort_q || lost) ? RECOV : ACK;
          cnt_d   = 4'd0;
        end
      end
      ACK: begin
        cnt_d = 4'd0;
        if (ds_s2_q) state_d = RECOV;
      end
      RECOV: begin
        abort_d = 1'b0;
        if (cnt_q == RECOV_LAST) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are glitch-free.
  always_comb begin
    cs_d    = !(state_d inside {SETUP, STROBE, HOLD});
    ben_d   = !(state_d inside {SETUP, STROBE, HOLD, ACK});
    rd_d    = !((state_d == STROBE) && dir_d);
    wr_d    = !((state_d == STROBE) && !dir_d);
    dtack_d = (state_d != ACK);
    busy_d  = (state_d != IDLE);
    dbdir_d = (state_d == IDLE) ? 1'b1 : dir_d;
  end

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      dir_q    <= 1'b1;
      abort_q  <= 1'b0;
      armed_q  <= 1'b0;
      sel_s1_q <= 1'b0;
      sel_s2_q <= 1'b0;
      ds_s1_q  <= 1'b1;
      ds_s2_q  <= 1'b1;
      vld_q    <= 2'b00;
      cs_q     <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      ben_q    <= 1'b1;
      dbdir_q  <= 1'b1;
      dtack_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      abort_q  <= abort_d;
      armed_q  <= armed_d;
      sel_s1_q <= wizsel;
      sel_s2_q <= sel_s1_q;
      ds_s1_q  <= dsl;
      ds_s2_q  <= ds_s1_q;
      vld_q    <= {vld_q[0], 1'b1};
      cs_q     <= cs_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ben_q    <= ben_d;
      dbdir_q  <= dbdir_d;
      dtack_q  <= dtack_d;
      busy_q   <= busy_d;
    end
  end

  assign wizcsl = cs_q;
  assign wizrdl = rd_q;
  assign wizwrl = wr_q;
  assign dbenl  = ben_q;
  assign dbdir  = dbdir_q;
  assign dtackl = dtack_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_wiz_bus_cycle.sv
// tb/tb_wiz_bus_cycle.sv - directed checks of wiz_bus_cycle timing, aborts and reset
module tb_wiz_bus_cycle;

  logic clk = 1'b0;
  logic rstl, wizsel, dsl, rdwl;
  logic [2:0] cs, rd, wr, ben, dir, dt, bsy;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wiz_bus_cycle u0 (
    .clk(clk), .rstl(rstl), .wizsel(wizsel), .dsl(dsl), .rdwl(rdwl),
    .wizcsl(cs[0]), .wizrdl(rd[0]), .wizwrl(wr[0]), .dbenl(ben[0]),
    .dbdir(dir[0]), .dtackl(dt[0]), .busy(bsy[0]));

  wiz_bus_cycle #(.SETUP_CYC(3), .STROBE_CYC(5)) u1 (
    .clk(clk), .rstl(rstl), .wizsel(wizsel), .dsl(dsl), .rdwl(rdwl),
    .wizcsl(cs[1]), .wizrdl(rd[1]), .wizwrl(wr[1]), .dbenl(ben[1]),
    .dbdir(dir[1]), .dtackl(dt[1]), .busy(bsy[1]));

  wiz_bus_cycle #(.STROBE_CYC(0)) u2 (
    .clk(clk), .rstl(rstl), .wizsel(wizsel), .dsl(dsl), .rdwl(rdwl),
    .wizcsl(cs[2]), .wizrdl(rd[2]), .wizwrl(wr[2]), .dbenl(ben[2]),
    .dbdir(dir[2]), .dtackl(dt[2]), .busy(bsy[2]));

  // Output vectors ordered {wizcsl, wizrdl, wizwrl, dbenl, dbdir, dtackl, busy}
  localparam logic [6:0] IDL  = 7'b1111110;
  localparam logic [6:0] SU_R = 7'b0110111;
  localparam logic [6:0] ST_R = 7'b0010111;
  localparam logic [6:0] HD_R = 7'b0110111;
  localparam logic [6:0] AK_R = 7'b1110101;
  localparam logic [6:0] RC_R = 7'b1111111;
  localparam logic [6:0] SU_W = 7'b0110011;
  localparam logic [6:0] ST_W = 7'b0100011;
  localparam logic [6:0] HD_W = 7'b0110011;
  localparam logic [6:0] AK_W = 7'b1110001;
  localparam logic [6:0] RC_W = 7'b1111011;

  typedef struct {
    logic       sel;
    logic       ds;
    logic       rdw;
    logic [6:0] exp;
    int         n;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [6:0] outs(input int i);
    return {cs[i], rd[i], wr[i], ben[i], dir[i], dt[i], bsy[i]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h want 'h%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic d, input logic r);
    wizsel = s;
    dsl    = d;
    rdwl   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b1);
  endtask

  task automatic add(input logic s, input logic d, input logic r, input logic [6:0] e, input int n);
    vec_t v;
    v.sel = s; v.ds = d; v.rdw = r; v.exp = e; v.n = n;
    tbl.push_back(v);
  endtask

  task automatic run_txn(input int idx, input logic rdw, input bit sel_pulse, input int ds_rise,
                         output int cs_len, output int cs_to_strb, output int rd_len,
                         output int wr_len, output int dt_len, output int dir_bad,
                         output int overlap, output bit done);
    int  cs_first;
    int  strb_first;
    bit  seen;
    cs_first = -1; strb_first = -1; seen = 0; done = 0;
    cs_len = 0; rd_len = 0; wr_len = 0; dt_len = 0; dir_bad = 0; overlap = 0;
    for (int t = 0; t < 80 && !done; t++) begin
      step(sel_pulse ? (t == 0) : 1'b1, (t < ds_rise) ? 1'b0 : 1'b1, rdw);
      if (!cs[idx]) begin
        cs_len++;
        if (cs_first < 0) cs_first = t;
      end
      if ((!rd[idx] || !wr[idx]) && strb_first < 0) strb_first = t;
      if (!rd[idx]) rd_len++;
      if (!wr[idx]) wr_len++;
      if (!dt[idx]) dt_len++;
      if (!rd[idx] && !wr[idx]) overlap++;
      if (bsy[idx]) begin
        seen = 1;
        if (dir[idx] != rdw) dir_bad++;
      end else if (seen) begin
        done = 1;
      end
    end
    cs_to_strb = (cs_first < 0 || strb_first < 0) ? -1 : strb_first - cs_first;
    idle(20);
  endtask

  initial begin
    int  cs_len, cs_to_strb, rd_len, wr_len, dt_len, dir_bad, overlap, busy_cnt;
    bit  done, found;

    add(1, 0, 1, IDL,  2);
    add(1, 0, 1, SU_R, 1);
    add(1, 0, 0, ST_R, 2);
    add(1, 0, 0, HD_R, 1);
    add(1, 0, 0, AK_R, 2);
    add(1, 1, 0, AK_R, 1);
    add(1, 0, 0, AK_R, 1);
    add(1, 0, 0, RC_R, 2);
    add(1, 0, 0, IDL,  1);
    add(1, 0, 0, SU_W, 1);
    add(1, 0, 0, ST_W, 1);
    add(1, 0, 1, ST_W, 1);
    add(1, 0, 1, HD_W, 1);
    add(1, 1, 1, AK_W, 2);
    add(1, 1, 1, RC_W, 2);
    add(1, 1, 1, IDL,  2);
    add(1, 0, 1, IDL,  2);
    add(1, 1, 1, SU_R, 1);
    add(1, 1, 1, ST_R, 2);
    add(1, 1, 1, HD_R, 1);
    add(1, 1, 1, RC_R, 2);
    add(1, 1, 1, IDL,  2);
    add(1, 0, 1, IDL,  2);
    add(0, 0, 1, SU_R, 1);
    add(0, 0, 1, ST_R, 2);
    add(0, 0, 1, HD_R, 1);
    add(1, 0, 1, RC_R, 2);
    add(1, 0, 1, IDL,  3);
    add(1, 1, 1, IDL,  2);
    add(1, 0, 1, IDL,  2);
    add(1, 0, 1, SU_R, 1);
    add(1, 1, 1, ST_R, 2);
    add(1, 1, 1, HD_R, 1);
    add(1, 1, 1, RC_R, 2);
    add(1, 1, 1, IDL,  1);

    rstl = 1'b0; wizsel = 1'b0; dsl = 1'b1; rdwl = 1'b1;
    #12;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_outs_u%0d", i), int'(outs(i)), int'(IDL));
    @(posedge clk);
    #1 rstl = 1'b1;
    idle(4);

    begin
      int row = 0;
      foreach (tbl[k]) begin
        for (int j = 0; j < tbl[k].n; j++) begin
          row++;
          step(tbl[k].sel, tbl[k].ds, tbl[k].rdw);
          chk($sformatf("vec_row%0d", row), int'(outs(0)), int'(tbl[k].exp));
        end
      end
    end
    idle(20);

    run_txn(1, 1'b0, 1'b0, 20, cs_len, cs_to_strb, rd_len, wr_len, dt_len, dir_bad, overlap, done);
    chk("u1_wr_done", int'(done), 1);
    chk("u1_wr_cs_to_strobe", cs_to_strb, 3);
    chk("u1_wr_strobe_len", wr_len, 5);
    chk("u1_wr_cs_len", cs_len, 9);
    chk("u1_wr_no_rd", rd_len, 0);
    chk("u1_wr_dbdir", dir_bad, 0);
    chk("u1_wr_dtack_seen", int'(dt_len > 0), 1);

    run_txn(1, 1'b0, 1'b1, 10, cs_len, cs_to_strb, rd_len, wr_len, dt_len, dir_bad, overlap, done);
    chk("u1_abort_done", int'(done), 1);
    chk("u1_abort_cs_len", cs_len, 1);
    chk("u1_abort_no_wr", wr_len, 0);
    chk("u1_abort_no_dtack", dt_len, 0);

    run_txn(2, 1'b1, 1'b0, 10, cs_len, cs_to_strb, rd_len, wr_len, dt_len, dir_bad, overlap, done);
    chk("u2_done", int'(done), 1);
    chk("u2_strobe0_len", rd_len, 1);
    chk("u2_cs_to_strobe", cs_to_strb, 1);
    chk("u2_cs_len", cs_len, 3);
    chk("u2_no_wr", wr_len, 0);
    chk("u2_no_overlap", overlap, 0);

    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      step(1'b1, 1'b0, 1'b1);
      if (!rd[0]) found = 1;
    end
    chk("rst_strobe_reached", int'(found), 1);
    #2 rstl = 1'b0;
    #1;
    chk("rst_async_u0", int'(outs(0)), int'(IDL));
    chk("rst_async_u1", int'(outs(1)), int'(IDL));
    repeat (2) @(posedge clk);
    #1 rstl = 1'b1;
    busy_cnt = 0;
    repeat (8) begin
      step(1'b1, 1'b0, 1'b1);
      busy_cnt += int'(bsy[0]);
    end
    chk("rst_no_restart", busy_cnt, 0);
    repeat (3) step(1'b1, 1'b1, 1'b1);
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      step(1'b1, 1'b0, 1'b1);
      if (!cs[0]) found = 1;
    end
    chk("rst_fresh_edge_start", int'(found), 1);
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
